// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused over WIDTH cycles, LSB first, valid/ready on both sides.
// Define BIT_SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module bit_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    // Holds the WIDTH-1 sum bits already produced; the last bit comes straight from the cell.
    logic [WIDTH-2:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             out_valid_q, out_valid_d;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_a, fa_b, fa_c;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] sum_cat;

    // The single full-adder cell, fed from the operand shift registers and the carry flop.
    always_comb begin
        fa_a  = a_sr_q[0];
        fa_b  = b_sr_q[0];
        fa_c  = carry_q;
        fa_s  = fa_a ^ fa_b ^ fa_c;
        fa_co = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));
    end

    assign sum_cat = {fa_s, sum_sr_q};

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        sum_sr_d    = sum_sr_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        out_valid_d = out_valid_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    sum_sr_d = '0;
                    carry_d  = c_in;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                sum_sr_d = sum_cat[WIDTH-1:1];
                carry_d  = fa_co;
                if (cnt_q == LAST_BIT) begin
                    // Counter holds on the last bit so it never wraps for power-of-two widths.
                    sum_d       = sum_cat;
                    c_out_d     = fa_co;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef BIT_SERIAL_ADDER_OVF_EN
                    ovf_d       = carry_q ^ fa_co;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            sum_sr_q    <= sum_sr_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder (WIDTH=8): directed cases plus randomized traffic against an arithmetic model.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
`ifdef BIT_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Returns {ovf, carry, sum} straight from integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci);
        int us, sx, sy, ss;
        logic [9:0] r;
        us = int'(x) + int'(y) + int'(ci);
        sx = (int'(x) > 127) ? int'(x) - 256 : int'(x);
        sy = (int'(y) > 127) ? int'(y) - 256 : int'(y);
        ss = sx + sy + int'(ci);
        r[7:0] = us[7:0];
        r[8]   = us[8];
        r[9]   = (ss > 127) || (ss < -128);
        return r;
    endfunction

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
        int         acc;
    } exp_t;

    exp_t q[$];
    bit   m_idle;
    bit   m_vld;
    logic [9:0] m_r;
    exp_t m_e;

    // Model: at most one transaction in flight; result due W edges after acceptance, retired on out_ready.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_in_ready", in_ready, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_sum", sum, 8'h00);
            chk("rst_c_out", c_out, 1'b0);
        end else begin
            m_idle = (q.size() == 0);
            m_vld  = !m_idle && (cyc >= q[0].acc + W);
            chk("mon_in_ready", in_ready, m_idle);
            chk("mon_busy", busy, !m_idle);
            chk("mon_out_valid", out_valid, m_vld);
            if (m_vld && out_valid) begin
                chk("mon_sum", sum, q[0].s);
                chk("mon_c_out", c_out, q[0].c);
`ifdef BIT_SERIAL_ADDER_OVF_EN
                chk("mon_ovf", ovf, q[0].o);
`endif
                if (out_ready) void'(q.pop_front());
            end
            if (m_idle && in_valid) begin
                m_r   = model(a, b, c_in);
                m_e.s = m_r[7:0];
                m_e.c = m_r[8];
                m_e.o = m_r[9];
                m_e.acc = cyc + 1;
                q.push_back(m_e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] aa, input logic [7:0] bb, input logic ci, output int acc);
        int i;
        i = 0;
        a = aa;
        b = bb;
        c_in = ci;
        in_valid = 1'b1;
        while (!in_ready && i < 64) begin
            step();
            i++;
        end
        chk("send_in_ready", in_ready, 1'b1);
        step();
        acc = cyc;
    endtask

    task automatic await_result(input string nm, input logic [7:0] es, input logic ec, output int rise);
        int i;
        i = 0;
        while (!out_valid && i < 64) begin
            step();
            i++;
        end
        rise = cyc;
        chk({nm, "_valid"}, out_valid, 1'b1);
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_c_out"}, c_out, ec);
    endtask

    int acc0, acc1, acc2, r0, r1, r2;
    logic [7:0] held;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        c_in = 1'b0;
        #1;
        chk("init_out_valid", out_valid, 1'b0);
        chk("init_in_ready", in_ready, 1'b1);
        chk("init_sum", sum, 8'h00);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        chk("pin_0f_01", model(8'h0F, 8'h01, 1'b0), 10'h010);
        chk("pin_ff_ff_1", model(8'hFF, 8'hFF, 1'b1), 10'h1FF);
        chk("pin_7f_01", model(8'h7F, 8'h01, 1'b0), 10'h280);
        chk("pin_80_80", model(8'h80, 8'h80, 1'b0), 10'h300);

        // Basic add, latency and in_ready recovery
        send(8'h0F, 8'h01, 1'b0, acc0);
        in_valid = 1'b0;
        await_result("t1", 8'h10, 1'b0, r0);
        chk("t1_latency", r0 - acc0, 8);
        chk("t1_in_ready_low", in_ready, 1'b0);
        step();
        chk("t1_in_ready_back", in_ready, 1'b1);

        send(8'hFF, 8'h01, 1'b0, acc0);
        in_valid = 1'b0;
        await_result("t2a", 8'h00, 1'b1, r0);
        step();
        send(8'hFF, 8'hFF, 1'b1, acc0);
        in_valid = 1'b0;
        await_result("t2b", 8'hFF, 1'b1, r0);
        step();

`ifdef BIT_SERIAL_ADDER_OVF_EN
        send(8'h7F, 8'h01, 1'b0, acc0);
        in_valid = 1'b0;
        await_result("ovf1", 8'h80, 1'b0, r0);
        chk("ovf1_ovf", ovf, 1'b1);
        step();
        send(8'h80, 8'h80, 1'b0, acc0);
        in_valid = 1'b0;
        await_result("ovf2", 8'h00, 1'b1, r0);
        chk("ovf2_ovf", ovf, 1'b1);
        step();
        send(8'hF0, 8'h05, 1'b0, acc0);
        in_valid = 1'b0;
        await_result("ovf3", 8'hF5, 1'b0, r0);
        chk("ovf3_ovf", ovf, 1'b0);
        step();
`endif

        // Backpressure with a new request waiting
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0, acc0);
        a = 8'h11;
        b = 8'h22;
        c_in = 1'b0;
        await_result("bp", 8'h46, 1'b0, r0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_sum", sum, 8'h46);
            chk("bp_hold_c_out", c_out, 1'b0);
            chk("bp_hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_idle", in_ready, 1'b1);
        step();
        chk("bp_accepted", busy, 1'b1);
        acc1 = cyc;
        in_valid = 1'b0;
        await_result("bp_new", 8'h33, 1'b0, r1);
        chk("bp_new_latency", r1 - acc1, 8);
        step();

        // Reset in the 4th SHIFT cycle
        send(8'h55, 8'hAA, 1'b0, acc0);
        in_valid = 1'b0;
        repeat (3) step();
        chk("rs_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rs_out_valid", out_valid, 1'b0);
        chk("rs_in_ready", in_ready, 1'b1);
        chk("rs_busy", busy, 1'b0);
        chk("rs_sum", sum, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        repeat (12) step();
        send(8'h03, 8'h04, 1'b0, acc0);
        in_valid = 1'b0;
        await_result("rs_after", 8'h07, 1'b0, r0);
        step();

        // Back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        send(8'h01, 8'h02, 1'b0, acc0);
        await_result("bb0", 8'h03, 1'b0, r0);
        send(8'h10, 8'h20, 1'b0, acc1);
        await_result("bb1", 8'h30, 1'b0, r1);
        send(8'h80, 8'h80, 1'b0, acc2);
        await_result("bb2", 8'h00, 1'b1, r2);
        in_valid = 1'b0;
        chk("bb_space01", r1 - r0, 10);
        chk("bb_space12", r2 - r1, 10);
        chk("bb_acc_space", acc1 - acc0, 10);
        step();

        // Randomized traffic; operands keep changing while busy
        for (int k = 0; k < 800; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            c_in = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();
        chk("drain_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
